// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: mode encodings and widths.
package led_seq_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_FADE  = 2'd3
  } mode_e;

  // Mode rotation order: OFF -> BLINK -> CHASE -> FADE -> OFF.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_OFF:   return MODE_BLINK;
      MODE_BLINK: return MODE_CHASE;
      MODE_CHASE: return MODE_FADE;
      default:    return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Control/status bundle of the LED sequencer. The controller (master) drives
// enable and mode requests; the sequencer (slave) returns LEDs, mode and tick.
interface led_sequencer_if;
  import led_seq_pkg::*;

  logic              enable;
  logic              mode_next;
  logic [3:0]        led;
  logic [MODE_W-1:0] mode;
  logic              tick;

  modport master (output enable, output mode_next,
                  input  led, input mode, input tick);
  modport slave  (input  enable, input mode_next,
                  output led, output mode, output tick);
endinterface

// File: rtl/led_sequencer_tick_gen.sv
// Step-rate prescaler: counts 0..DIV-1 while enabled and flags the last count.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);

  // Prescaler count: clear wins over counting; disabled holds the value.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      r_cnt <= '0;
    else if (CLR) r_cnt <= '0;
    else if (EN)  r_cnt <= w_last ? '0 : r_cnt + 1'b1;
  end

  // Tick is suppressed while disabled so a frozen count cannot re-fire it.
  assign TICK = EN & w_last;

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: mode FSM, step counter, fade PWM and registered LED mux.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int CLK_HZ   = 12000000,
  parameter int STEP_HZ  = 10,
  parameter int PWM_BITS = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENABLE,
  input  logic              MODE_NEXT,
  output logic              LED0,
  output logic              LED1,
  output logic              LED2,
  output logic              LED3,
  output logic [MODE_W-1:0] MODE,
  output logic              TICK
);

  localparam int DIV    = CLK_HZ / STEP_HZ;
  localparam int STEP_W = PWM_BITS + 1;

  mode_e               r_mode;
  mode_e               w_mode_nxt;
  logic                w_adv;
  logic                w_tick;
  logic [STEP_W-1:0]   r_step;
  logic [PWM_BITS-1:0] r_pwm;
  logic [PWM_BITS-1:0] w_duty;
  logic [3:0]          r_led;
  logic [3:0]          w_led_nxt;

  // Mode requests are only honoured while the sequencer is enabled.
  assign w_adv = ENABLE & MODE_NEXT;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (ENABLE),
    .CLR  (w_adv),
    .TICK (w_tick)
  );

  // Mode state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_mode <= MODE_OFF;
    else     r_mode <= w_mode_nxt;
  end

  // Mode next-state: advance one position per accepted request.
  // NOTE: assigning a default first keeps every path assigned, so no latch is inferred.
  always_comb begin
    w_mode_nxt = r_mode;
    if (w_adv) w_mode_nxt = next_mode(r_mode);
  end

  // Step counter: a mode change restarts the pattern and beats a coincident tick.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         r_step <= '0;
    else if (w_adv)  r_step <= '0;
    else if (w_tick) r_step <= r_step + 1'b1;
  end

  // Free-running PWM phase counter for the fade mode.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_pwm <= '0;
    else     r_pwm <= r_pwm + 1'b1;
  end

  // Triangle duty: ramp up on the lower half of the step range, down on the upper.
  assign w_duty = r_step[PWM_BITS] ? ~r_step[PWM_BITS-1:0] : r_step[PWM_BITS-1:0];

  // LED pattern selection from the current mode and step.
  always_comb begin
    w_led_nxt = '0;
    if (ENABLE) begin
      case (r_mode)
        MODE_BLINK: w_led_nxt = {4{r_step[0]}};
        MODE_CHASE: w_led_nxt = 4'b0001 << r_step[1:0];
        MODE_FADE:  w_led_nxt = {4{(r_pwm < w_duty)}};
        default:    w_led_nxt = '0;
      endcase
    end
  end

  // Registered LED drives.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_led <= '0;
    else     r_led <= w_led_nxt;
  end

  assign {LED3, LED2, LED1, LED0} = r_led;
  assign MODE = r_mode;
  assign TICK = w_tick;

endmodule
